// File: rtl/apb_master_wt.sv
// APB requester: turns single-beat commands into SETUP/ACCESS transfers,
// honouring PREADY wait states with an optional wait-state timeout abort.
module apb_master_wt #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic              PREADY,
  input  logic              PSLVERR,
  input  logic [DATA_W-1:0] PRDATA
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  localparam logic [7:0] TO_LIM = 8'(TIMEOUT);
  localparam bit         TO_EN  = (TIMEOUT != 0);

  state_t              state_q, state_d;
  logic                psel_q, psel_d;
  logic                penable_q, penable_d;
  logic                pwrite_q, pwrite_d;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic [DATA_W-1:0]   pwdata_q, pwdata_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;
  logic                rsp_timeout_q, rsp_timeout_d;
  logic [7:0]          wait_cnt_q, wait_cnt_d;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q       <= IDLE;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
      wait_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      pwrite_q      <= pwrite_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
      wait_cnt_q    <= wait_cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    psel_d        = psel_q;
    penable_d     = penable_q;
    pwrite_d      = pwrite_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    rsp_valid_d   = 1'b0;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;
    wait_cnt_d    = wait_cnt_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          paddr_d    = cmd_addr;
          pwrite_d   = cmd_write;
          pwdata_d   = cmd_wdata;
          psel_d     = 1'b1;
          penable_d  = 1'b0;
          wait_cnt_d = '0;
          state_d    = SETUP;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
      end
      ACCESS: begin
        if (PREADY) begin
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_err_d     = PSLVERR;
          rsp_timeout_d = 1'b0;
          rsp_rdata_d   = pwrite_q ? '0 : PRDATA;
          state_d       = IDLE;
        end else if (TO_EN && wait_cnt_q == TO_LIM) begin
          // TIMEOUT wait cycles have already elapsed with PREADY still low
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
          rsp_rdata_d   = '0;
          state_d       = IDLE;
        end else if (wait_cnt_q != 8'hFF) begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Gated with PRESETn so every output reads 0 while reset is held
  assign cmd_ready   = (state_q == IDLE) && PRESETn;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;
  assign PSEL        = psel_q;
  assign PENABLE     = penable_q;
  assign PWRITE      = pwrite_q;
  assign PADDR       = paddr_q;
  assign PWDATA      = pwdata_q;

endmodule

// File: tb/tb_apb_master_wt.sv
// Directed bench for apb_master_wt: timing, wait states, errors, timeout, reset.
module tb_apb_master_wt;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0, cmd_write = 1'b0;
  logic [7:0] cmd_addr = '0, cmd_wdata = '0;
  logic       cmd_ready, rsp_valid, rsp_err, rsp_timeout;
  logic [7:0] rsp_rdata;
  logic       psel, penable, pwrite;
  logic [7:0] paddr, pwdata;
  logic       pready = 1'b0, pslverr = 1'b0;
  logic [7:0] prdata = '0;

  logic       cmd_valid0 = 1'b0, pready0 = 1'b0;
  logic       cmd_ready0, rsp_valid0, rsp_err0, rsp_timeout0;
  logic [7:0] rsp_rdata0, paddr0, pwdata0;
  logic       psel0, penable0, pwrite0;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  apb_master_wt #(.ADDR_W(8), .DATA_W(8), .TIMEOUT(15)) dut (
    .PCLK(clk), .PRESETn(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .rsp_timeout(rsp_timeout),
    .PSEL(psel), .PENABLE(penable), .PWRITE(pwrite), .PADDR(paddr),
    .PWDATA(pwdata), .PREADY(pready), .PSLVERR(pslverr), .PRDATA(prdata)
  );

  apb_master_wt #(.ADDR_W(8), .DATA_W(8), .TIMEOUT(0)) dut0 (
    .PCLK(clk), .PRESETn(rst_n),
    .cmd_valid(cmd_valid0), .cmd_ready(cmd_ready0), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid0), .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err0),
    .rsp_timeout(rsp_timeout0),
    .PSEL(psel0), .PENABLE(penable0), .PWRITE(pwrite0), .PADDR(paddr0),
    .PWDATA(pwdata0), .PREADY(pready0), .PSLVERR(pslverr), .PRDATA(prdata)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents a command for one edge; returns in cycle N+1 after accept edge N
  task automatic issue(input logic w, input logic [7:0] a, input logic [7:0] d);
    cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    total_cnt++; if ({psel, penable, pwrite, paddr, pwdata} !== 19'd0) $display("FAIL reset_apb: got %b want 0", {psel, penable, pwrite, paddr, pwdata}); else pass_cnt++;
    total_cnt++; if ({rsp_valid, rsp_rdata, rsp_err, rsp_timeout} !== 11'd0) $display("FAIL reset_rsp: got %b want 0", {rsp_valid, rsp_rdata, rsp_err, rsp_timeout}); else pass_cnt++;
    step(); step();
    rst_n = 1'b1;
    step();
    total_cnt++; if (cmd_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", cmd_ready); else pass_cnt++;
    $display("reset released, cmd_ready=%b", cmd_ready);
  endtask

  task automatic test_write_zero_wait();
    issue(1'b1, 8'h03, 8'hA5);
    total_cnt++; if ({psel, penable, cmd_ready} !== 3'b100) $display("FAIL wr_setup: psel/penable/ready got %b want 100", {psel, penable, cmd_ready}); else pass_cnt++;
    pready = 1'b1;
    step();
    total_cnt++; if ({psel, penable, pwrite, paddr, pwdata} !== {3'b111, 8'h03, 8'hA5}) $display("FAIL wr_access: got %b/%h/%h want 111/03/a5", {psel, penable, pwrite}, paddr, pwdata); else pass_cnt++;
    total_cnt++; if (rsp_valid !== 1'b0) $display("FAIL wr_early_rsp: got %b want 0", rsp_valid); else pass_cnt++;
    step();
    pready = 1'b0;
    total_cnt++; if ({rsp_valid, rsp_err, rsp_timeout, rsp_rdata} !== {3'b100, 8'h00}) $display("FAIL wr_rsp: got v/e/t=%b rdata=%h want 100/00", {rsp_valid, rsp_err, rsp_timeout}, rsp_rdata); else pass_cnt++;
    total_cnt++; if ({psel, penable, cmd_ready} !== 3'b001) $display("FAIL wr_done: psel/penable/ready got %b want 001", {psel, penable, cmd_ready}); else pass_cnt++;
    $display("xfer write addr=03 data=a5 rsp_err=%b", rsp_err);
    step();
    total_cnt++; if (rsp_valid !== 1'b0) $display("FAIL wr_pulse: got %b want 0", rsp_valid); else pass_cnt++;
    total_cnt++; if ({paddr, pwdata} !== {8'h03, 8'hA5}) $display("FAIL wr_hold: got %h/%h want 03/a5", paddr, pwdata); else pass_cnt++;
  endtask

  task automatic test_read_wait();
    int bad = 0;
    issue(1'b0, 8'h04, 8'hEE);
    prdata = 8'h11;
    for (int c = 2; c <= 4; c++) begin
      step();
      if (paddr !== 8'h04 || pwrite !== 1'b0 || rsp_valid !== 1'b0) bad++;
      if (c == 4) begin pready = 1'b1; prdata = 8'h4F; end
    end
    total_cnt++; if (bad !== 0) $display("FAIL rd_stable: got %0d bad cycles want 0", bad); else pass_cnt++;
    total_cnt++; if (penable !== 1'b1) $display("FAIL rd_penable: got %b want 1", penable); else pass_cnt++;
    step();
    pready = 1'b0; prdata = 8'h00;
    total_cnt++; if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b10, 8'h4F}) $display("FAIL rd_rsp: got v/e=%b rdata=%h want 10/4f", {rsp_valid, rsp_err}, rsp_rdata); else pass_cnt++;
    $display("xfer read addr=04 waits=2 rdata=%h", rsp_rdata);
    step();
    total_cnt++; if (rsp_rdata !== 8'h4F) $display("FAIL rd_hold: got %h want 4f", rsp_rdata); else pass_cnt++;
  endtask

  task automatic test_timeout();
    int lat = 1;
    issue(1'b0, 8'h30, 8'h00);
    while (rsp_valid !== 1'b1 && lat < 40) begin
      step();
      lat++;
    end
    total_cnt++; if (lat !== 18) $display("FAIL to_latency: got %0d cycles want 18", lat); else pass_cnt++;
    total_cnt++; if ({rsp_err, rsp_timeout, rsp_rdata, psel, penable} !== {2'b11, 8'h00, 2'b00}) $display("FAIL to_rsp: got e/t=%b rdata=%h psel/pen=%b want 11/00/00", {rsp_err, rsp_timeout}, rsp_rdata, {psel, penable}); else pass_cnt++;
    $display("xfer read addr=30 timeout after %0d cycles", lat);
    step();
  endtask

  task automatic test_slverr();
    issue(1'b1, 8'h20, 8'h5A);
    step();
    pready = 1'b1; pslverr = 1'b1;
    step();
    pready = 1'b0; pslverr = 1'b0;
    total_cnt++; if ({rsp_valid, rsp_err, rsp_timeout, rsp_rdata} !== {3'b110, 8'h00}) $display("FAIL err_rsp: got v/e/t=%b rdata=%h want 110/00", {rsp_valid, rsp_err, rsp_timeout}, rsp_rdata); else pass_cnt++;
    $display("xfer write addr=20 rsp_err=%b", rsp_err);
    step(); step();
    total_cnt++; if (rsp_err !== 1'b1) $display("FAIL err_hold: got %b want 1", rsp_err); else pass_cnt++;
    issue(1'b1, 8'h20, 8'h5B);
    step();
    pslverr = 1'b1;
    step();
    pslverr = 1'b0; pready = 1'b1;
    step();
    pready = 1'b0;
    total_cnt++; if ({rsp_valid, rsp_err} !== 2'b10) $display("FAIL err_ignore_wait: got v/e=%b want 10", {rsp_valid, rsp_err}); else pass_cnt++;
    $display("xfer write addr=20 wait-cycle pslverr rsp_err=%b", rsp_err);
    step();
  endtask

  task automatic test_back_to_back();
    cmd_write = 1'b1; cmd_addr = 8'h10; cmd_wdata = 8'h11; cmd_valid = 1'b1;
    pready = 1'b1;
    step();
    cmd_addr = 8'h12; cmd_wdata = 8'h22;
    step();
    total_cnt++; if (cmd_ready !== 1'b0) $display("FAIL b2b_busy: cmd_ready got %b want 0", cmd_ready); else pass_cnt++;
    step();
    total_cnt++; if ({rsp_valid, psel, cmd_ready} !== 3'b101) $display("FAIL b2b_gap: rsp_valid/psel/ready got %b want 101", {rsp_valid, psel, cmd_ready}); else pass_cnt++;
    $display("xfer write addr=10 b2b first rsp_valid=%b", rsp_valid);
    step();
    cmd_valid = 1'b0;
    total_cnt++; if ({psel, penable, rsp_valid, paddr, pwdata} !== {3'b100, 8'h12, 8'h22}) $display("FAIL b2b_second: got %b/%h/%h want 100/12/22", {psel, penable, rsp_valid}, paddr, pwdata); else pass_cnt++;
    step(); step();
    pready = 1'b0;
    total_cnt++; if (rsp_valid !== 1'b1) $display("FAIL b2b_rsp2: got %b want 1", rsp_valid); else pass_cnt++;
    $display("xfer write addr=12 b2b second rsp_valid=%b", rsp_valid);
    step();
  endtask

  task automatic test_no_timeout();
    int seen = 0;
    cmd_write = 1'b0; cmd_addr = 8'h44; cmd_valid0 = 1'b1;
    step();
    cmd_valid0 = 1'b0;
    repeat (300) begin
      step();
      if (rsp_valid0 !== 1'b0) seen++;
    end
    total_cnt++; if (seen !== 0 || {psel0, penable0} !== 2'b11) $display("FAIL to0_hold: rsp seen %0d psel/pen=%b want 0/11", seen, {psel0, penable0}); else pass_cnt++;
    pready0 = 1'b1; prdata = 8'h77;
    step();
    pready0 = 1'b0; prdata = 8'h00;
    total_cnt++; if ({rsp_valid0, rsp_timeout0, rsp_rdata0} !== {2'b10, 8'h77}) $display("FAIL to0_rsp: got v/t=%b rdata=%h want 10/77", {rsp_valid0, rsp_timeout0}, rsp_rdata0); else pass_cnt++;
    $display("xfer read addr=44 TIMEOUT=0 after 300 waits rdata=%h", rsp_rdata0);
    step();
  endtask

  task automatic test_reset_mid_access();
    int seen = 0;
    issue(1'b0, 8'h55, 8'h00);
    step(); step();
    #2 rst_n = 1'b0;
    #1;
    total_cnt++; if ({psel, penable, rsp_valid, rsp_err, paddr} !== {4'b0000, 8'h00}) $display("FAIL rst_async: got %b/%h want 0000/00", {psel, penable, rsp_valid, rsp_err}, paddr); else pass_cnt++;
    step();
    rst_n = 1'b1;
    repeat (4) begin
      step();
      if (rsp_valid !== 1'b0 || psel !== 1'b0) seen++;
    end
    total_cnt++; if (seen !== 0 || cmd_ready !== 1'b1) $display("FAIL rst_after: bad %0d ready=%b want 0/1", seen, cmd_ready); else pass_cnt++;
    $display("reset mid-access dropped transfer, cmd_ready=%b", cmd_ready);
  endtask

  initial begin
    test_reset();
    test_write_zero_wait();
    test_read_wait();
    test_timeout();
    test_slverr();
    test_back_to_back();
    test_no_timeout();
    test_reset_mid_access();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
